rtc_tick_counter: RTL and testbench
===================================

Name: rtc_tick_counter

Overview:
- Free-running real-time counter for the RV32 SoC, clocked from the 24 MHz core clock.
- Keeps a sub-second tick field (0..TICKS_PER_SEC-1) and a seconds field.
- Normalises out-of-range sub-second writes into the seconds field, so readers always see a canonical {sec, sub} pair.
- Provides the CPU MMIO register port, a seconds pulse, and a seconds-compare interrupt.

Parameters:
- TICKS_PER_SEC, 24000000, sub-second wrap value; ticks per second.
- SUB_W, 30, width of the sub-second field; 2^SUB_W must exceed TICKS_PER_SEC.
- SEC_W, 32, width of the seconds field.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; a tick is counted on each clk edge where en=1.
- wr_en  input  1  register write strobe, single cycle.
- wr_sel  input  2  write target: 0=SUB, 1=SEC, 2=CMP, 3=CTRL.
- wr_data  input  32  write data; SUB uses bits [SUB_W-1:0].
- rd_en  input  1  register read strobe.
- rd_sel  input  2  read target: 0=SUB, 1=SEC (snapshot), 2=CMP, 3=STATUS.
- rd_data  output  32  registered read data.
- sub_cnt  output  SUB_W  live sub-second count.
- sec_cnt  output  SEC_W  live seconds count.
- sec_pulse  output  1  one-cycle pulse on each natural seconds rollover.
- busy  output  1  high while normalisation is in progress.
- irq  output  1  sticky compare interrupt.
- irq_ack  input  1  clears irq.

Behaviour:
Reset (asynchronous, immediate):
- sub_cnt=0, sec_cnt=0, cmp=all-ones, irq_en=0, irq=0, sec_pulse=0, rd_data=0, snapshot=0, busy=0, FSM=RUN.
- Reset asserted mid-normalisation aborts it.

FSM states:
- RUN to NORM: SUB write with wr_data[SUB_W-1:0] >= TICKS_PER_SEC. The written value is loaded into sub_cnt.
- NORM: each cycle, sub_cnt -= TICKS_PER_SEC and sec_cnt += 1. Return to RUN on the cycle in which the result is < TICKS_PER_SEC.
- Worst case at SUB_W=30 is 44 cycles.
- busy=1 exactly while in NORM.
- In NORM, en is ignored (ticks are lost, by design), all writes are ignored, and reads still complete.

RUN counting:
- If en=1 and no write to SUB or SEC this cycle: sub_cnt==TICKS_PER_SEC-1 gives sub_cnt<=0, sec_cnt<=sec_cnt+1, and sec_pulse=1 on the next cycle. Otherwise sub_cnt<=sub_cnt+1.
- sec_cnt wraps modulo 2^SEC_W silently.
- An in-range SUB write (< TICKS_PER_SEC) loads directly and suppresses that cycle's increment.
- A SEC write loads sec_cnt and suppresses that cycle's increment of both fields.
- Write always wins over count.
- Normalisation increments never raise sec_pulse.

CTRL write:
- bit0 = irq_en.
- bit1 = 1 clears irq (self-clearing, not stored).

irq:
- Set on the cycle after sec_cnt transitions to a value equal to cmp, through either a natural rollover or a NORM step, while irq_en=1.
- Direct SEC or CMP writes that create equality do not set irq.
- Cleared by irq_ack or CTRL bit1.
- Set and clear in the same cycle: set wins.

Reads (one-cycle latency):
- rd_data is valid the cycle after rd_en.
- A SUB read returns sub_cnt and atomically latches sec_cnt into the snapshot. The snapshot uses the post-rollover value if a rollover occurs in the same cycle, so {SEC, SUB} read in order is coherent.
- A SEC read returns the snapshot.
- A STATUS read returns {29'b0, busy, irq, irq_en}.
- Unused upper bits read as 0.

Test Plan:
- Reset, en=1 for 24,000,000 cycles -> sub_cnt wraps 23,999,999 to 0, sec_cnt=1, exactly one sec_pulse.
- Write SUB=23,999,998 with en=1, wait 3 cycles -> sec_cnt +1 and sub_cnt=1. A SEC write on the rollover cycle wins, with no increment and no pulse.
- Write SUB=50,000,005 -> busy for 2 cycles, then sub_cnt=2,000,005 and sec_cnt +2. Writes during busy are ignored. rst mid-NORM gives all zeros.
- CMP=3, CTRL=1, run through three rollovers -> irq rises one cycle after sec_cnt becomes 3. Writing SEC=3 directly does not set irq. irq_ack clears it. Set and ack in the same cycle leaves irq=1.
- Set sub_cnt=23,999,999 and sec_cnt=7. Read SUB on the rollover cycle, then read SEC -> SUB read gives 23,999,999 per timing and SEC read gives a value coherent with it (8 if the rollover is captured, else 7). No mixed pair.
- Write SUB=1,073,741,823 (the maximum) -> after 44 NORM cycles, sub_cnt=17,741,823 and sec_cnt +44.

Source files
------------

// File: rtl/rtc_tick_counter_if.sv
// rtl/rtc_tick_counter_if.sv - register bus for the RTC tick counter
interface rtc_tick_counter_if;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [1:0]  rd_sel;
    logic [31:0] rd_data;

    modport master (
        output wr_en, wr_sel, wr_data, rd_en, rd_sel,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rd_en, rd_sel,
        output rd_data
    );
endinterface

// File: rtl/rtc_tick_counter.sv
// rtl/rtc_tick_counter.sv - free-running {sec, sub} real-time counter with compare irq
module rtc_tick_counter #(
    parameter int unsigned TICKS_PER_SEC = 24000000,
    parameter int unsigned SUB_W         = 30,
    parameter int unsigned SEC_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    rtc_tick_counter_if.slave    bus,
    output logic [SUB_W-1:0]     sub_cnt,
    output logic [SEC_W-1:0]     sec_cnt,
    output logic                 sec_pulse,
    output logic                 busy,
    output logic                 irq,
    input  logic                 irq_ack
);

    typedef enum logic {RUN, NORM} state_t;

    localparam logic [SUB_W-1:0] TPS     = SUB_W'(TICKS_PER_SEC);
    localparam logic [SUB_W-1:0] TPS_M1  = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [SUB_W-1:0] SUB_ONE = SUB_W'(1);
    localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);

    state_t             state_q, state_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [SEC_W-1:0]   cmp_q;
    logic [SEC_W-1:0]   snap_q;
    logic [31:0]        rd_data_q;
    logic               irq_en_q;
    logic               irq_q;
    logic               hit_q;
    logic               sec_pulse_q;
    logic               rollover;
    logic               norm_step;
    logic               inc_hit;

    logic               wr_sub, wr_sec, wr_cmp, wr_ctrl;
    logic               irq_clr;
    logic [SUB_W-1:0]   sub_wdata;

    // Writes are only accepted in RUN; NORM owns both count fields.
    assign wr_sub    = bus.wr_en && (bus.wr_sel == 2'd0) && (state_q == RUN);
    assign wr_sec    = bus.wr_en && (bus.wr_sel == 2'd1) && (state_q == RUN);
    assign wr_cmp    = bus.wr_en && (bus.wr_sel == 2'd2) && (state_q == RUN);
    assign wr_ctrl   = bus.wr_en && (bus.wr_sel == 2'd3) && (state_q == RUN);
    assign irq_clr   = wr_ctrl && bus.wr_data[1];
    assign sub_wdata = bus.wr_data[SUB_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sub_d     = sub_q;
        sec_d     = sec_q;
        rollover  = 1'b0;
        norm_step = 1'b0;
        case (state_q)
            RUN: begin
                if (wr_sub) begin
                    sub_d = sub_wdata;
                    if (sub_wdata >= TPS) begin
                        state_d = NORM;
                    end
                end
                if (wr_sec) begin
                    sec_d = SEC_W'(bus.wr_data);
                end
                if (en && !wr_sub && !wr_sec) begin
                    if (sub_q == TPS_M1) begin
                        sub_d    = '0;
                        sec_d    = sec_q + SEC_ONE;
                        rollover = 1'b1;
                    end else begin
                        sub_d = sub_q + SUB_ONE;
                    end
                end
            end
            NORM: begin
                sub_d     = sub_q - TPS;
                sec_d     = sec_q + SEC_ONE;
                norm_step = 1'b1;
                if (sub_d < TPS) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Only counted seconds arm the compare; direct loads never do.
    assign inc_hit = (rollover || norm_step) && (sec_d == cmp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q       <= '0;
            sec_q       <= '0;
            cmp_q       <= '1;
            snap_q      <= '0;
            rd_data_q   <= '0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            hit_q       <= 1'b0;
            sec_pulse_q <= 1'b0;
        end else begin
            sub_q       <= sub_d;
            sec_q       <= sec_d;
            sec_pulse_q <= rollover;
            hit_q       <= inc_hit;
            if (wr_cmp) begin
                cmp_q <= SEC_W'(bus.wr_data);
            end
            if (wr_ctrl) begin
                irq_en_q <= bus.wr_data[0];
            end
            if (hit_q && irq_en_q) begin
                irq_q <= 1'b1;
            end else if (irq_ack || irq_clr) begin
                irq_q <= 1'b0;
            end
            // Snapshot takes the post-update seconds so a same-cycle rollover is included.
            if (bus.rd_en) begin
                case (bus.rd_sel)
                    2'd0: begin
                        rd_data_q <= 32'(sub_q);
                        snap_q    <= sec_d;
                    end
                    2'd1:    rd_data_q <= 32'(snap_q);
                    2'd2:    rd_data_q <= 32'(cmp_q);
                    default: rd_data_q <= {29'b0, busy, irq_q, irq_en_q};
                endcase
            end
        end
    end

    assign busy        = (state_q == NORM);
    assign sub_cnt     = sub_q;
    assign sec_cnt     = sec_q;
    assign sec_pulse   = sec_pulse_q;
    assign irq         = irq_q;
    assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_rtc_tick_counter.sv
// tb/tb_rtc_tick_counter.sv - self-checking bench for rtc_tick_counter
module tb_rtc_tick_counter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        irq_ack;
    logic [29:0] sub_cnt;
    logic [31:0] sec_cnt;
    logic        sec_pulse;
    logic        busy;
    logic        irq;

    rtc_tick_counter_if bus();

    rtc_tick_counter dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (bus),
        .sub_cnt   (sub_cnt),
        .sec_cnt   (sec_cnt),
        .sec_pulse (sec_pulse),
        .busy      (busy),
        .irq       (irq),
        .irq_ack   (irq_ack)
    );

    localparam logic [1:0] S_SUB = 2'd0, S_SEC = 2'd1, S_CMP = 2'd2, S_CTL = 2'd3;

    typedef struct {
        bit          do_wr;
        logic [1:0]  sel;
        logic [31:0] data;
        bit          en_v;
        int          n;
        logic [31:0] exp_sub;
        logic [31:0] exp_sec;
        bit          exp_busy;
    } vec_t;

    vec_t        vt[13];
    logic [31:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Read scoreboard: expected values queued at issue, popped when rd_data is due.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            #1;
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", bus.rd_data, 32'hxxxxxxxx);
            end else begin
                chk("rd_data", bus.rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] data, input logic en_v);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_data = data;
        en          = en_v;
        cycle();
        bus.wr_en   = 1'b0;
        en          = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, input logic [31:0] exp);
        bus.rd_en  = 1'b1;
        bus.rd_sel = sel;
        exp_q.push_back(exp);
        cycle();
        bus.rd_en  = 1'b0;
    endtask

    initial begin
        int cnt;
        int pulses;
        bit pulse_ok;

        rst         = 1'b1;
        en          = 1'b0;
        irq_ack     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 2'd0;
        bus.wr_data = 32'd0;
        bus.rd_en   = 1'b0;
        bus.rd_sel  = 2'd0;
        cycle();
        cycle();
        chk("reset_sub", 32'(sub_cnt), 32'd0);
        chk("reset_sec", sec_cnt, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_pulse", 32'(sec_pulse), 32'd0);
        chk("reset_rd_data", bus.rd_data, 32'd0);
        rst = 1'b0;
        cycle();
        rd(S_CMP, 32'hFFFF_FFFF);
        rd(S_CTL, 32'd0);

        vt[0]  = '{1, S_SUB, 32'd5,          1, 1, 32'd5,          32'd0,          0};
        vt[1]  = '{0, S_SUB, 32'd0,          1, 3, 32'd8,          32'd0,          0};
        vt[2]  = '{0, S_SUB, 32'd0,          0, 4, 32'd8,          32'd0,          0};
        vt[3]  = '{1, S_SEC, 32'd100,        1, 1, 32'd8,          32'd100,        0};
        vt[4]  = '{1, S_SUB, 32'd23999998,   1, 4, 32'd1,          32'd101,        0};
        vt[5]  = '{1, S_SUB, 32'd50000005,   1, 1, 32'd50000005,   32'd101,        1};
        vt[6]  = '{0, S_SUB, 32'd0,          1, 1, 32'd26000005,   32'd102,        1};
        vt[7]  = '{0, S_SUB, 32'd0,          1, 1, 32'd2000005,    32'd103,        0};
        vt[8]  = '{1, S_SEC, 32'hFFFF_FFFF,  0, 1, 32'd2000005,    32'hFFFF_FFFF,  0};
        vt[9]  = '{1, S_SUB, 32'd23999999,   1, 2, 32'd0,          32'd0,          0};
        vt[10] = '{1, S_SUB, 32'd24000000,   0, 2, 32'd0,          32'd1,          0};
        vt[11] = '{1, S_SUB, 32'd23999999,   0, 1, 32'd23999999,   32'd1,          0};
        vt[12] = '{1, S_SUB, 32'hC000_0007,  0, 1, 32'd7,          32'd1,          0};

        for (int i = 0; i < 13; i++) begin
            if (vt[i].do_wr) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = vt[i].sel;
                bus.wr_data = vt[i].data;
            end
            en = vt[i].en_v;
            cycle();
            bus.wr_en = 1'b0;
            for (int k = 1; k < vt[i].n; k++) cycle();
            en = 1'b0;
            chk($sformatf("vec%0d_sub", i), 32'(sub_cnt), vt[i].exp_sub);
            chk($sformatf("vec%0d_sec", i), sec_cnt, vt[i].exp_sec);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
        end

        // Exactly one pulse across a natural rollover, coincident with sub=0.
        wr(S_SUB, 32'd23999997, 1'b0);
        pulses   = 0;
        pulse_ok = 1'b1;
        en       = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (sec_pulse) begin
                pulses++;
                if (sub_cnt != 30'd0) pulse_ok = 1'b0;
            end
        end
        en = 1'b0;
        chk("pulse_count", pulses, 1);
        chk("pulse_aligned", 32'(pulse_ok), 32'd1);
        chk("pulse_sec", sec_cnt, 32'd2);
        chk("pulse_sub", 32'(sub_cnt), 32'd3);

        // SEC write on the rollover cycle wins.
        wr(S_SUB, 32'd23999999, 1'b0);
        wr(S_SEC, 32'd50, 1'b1);
        chk("secwr_sec", sec_cnt, 32'd50);
        chk("secwr_sub", 32'(sub_cnt), 32'd23999999);
        chk("secwr_pulse", 32'(sec_pulse), 32'd0);
        en = 1'b1;
        cycle();
        en = 1'b0;
        chk("roll_sec", sec_cnt, 32'd51);
        chk("roll_pulse", 32'(sec_pulse), 32'd1);
        cycle();
        chk("pulse_one_cycle", 32'(sec_pulse), 32'd0);

        // Writes during NORM are ignored; reads still complete.
        wr(S_SUB, 32'd50000005, 1'b0);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = S_SEC;
        bus.wr_data = 32'd999;
        rd(S_CTL, 32'h4);
        bus.wr_sel  = S_CMP;
        bus.wr_data = 32'd52;
        cycle();
        bus.wr_en   = 1'b0;
        chk("normwr_sub", 32'(sub_cnt), 32'd2000005);
        chk("normwr_sec", sec_cnt, 32'd53);
        chk("normwr_busy", 32'(busy), 32'd0);
        rd(S_CMP, 32'hFFFF_FFFF);

        // Coherent {SEC, SUB} read across a rollover.
        wr(S_SUB, 32'd23999999, 1'b0);
        wr(S_SEC, 32'd7, 1'b0);
        en = 1'b1;
        rd(S_SUB, 32'd23999999);
        en = 1'b0;
        rd(S_SEC, 32'd8);
        chk("coh_sec", sec_cnt, 32'd8);
        rd(S_SUB, 32'd0);
        rd(S_SEC, 32'd8);

        // Compare interrupt via natural rollovers.
        wr(S_CMP, 32'd3, 1'b0);
        wr(S_CTL, 32'd1, 1'b0);
        rd(S_CTL, 32'd1);
        rd(S_CMP, 32'd3);
        wr(S_SEC, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wr(S_SUB, 32'd23999999, 1'b0);
            en = 1'b1;
            cycle();
            en = 1'b0;
            chk($sformatf("irq_pre%0d", k), 32'(irq), 32'd0);
        end
        chk("irq_sec3", sec_cnt, 32'd3);
        cycle();
        chk("irq_set", 32'(irq), 32'd1);
        rd(S_CTL, 32'd3);
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
        chk("irq_ack", 32'(irq), 32'd0);
        wr(S_SEC, 32'd3, 1'b0);
        wr(S_CMP, 32'd3, 1'b0);
        cycle();
        cycle();
        chk("irq_direct", 32'(irq), 32'd0);

        // Set and ack in the same cycle: set wins.
        wr(S_SEC, 32'd2, 1'b0);
        wr(S_SUB, 32'd23999999, 1'b0);
        en = 1'b1;
        cycle();
        en = 1'b0;
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
        chk("irq_set_wins", 32'(irq), 32'd1);
        cycle();
        chk("irq_sticky", 32'(irq), 32'd1);
        wr(S_CTL, 32'd3, 1'b0);
        chk("irq_ctrl_clr", 32'(irq), 32'd0);
        rd(S_CTL, 32'd1);

        // Compare hit through a NORM step.
        wr(S_SEC, 32'd1, 1'b0);
        wr(S_SUB, 32'd50000005, 1'b0);
        cycle();
        cycle();
        chk("irq_norm_sec", sec_cnt, 32'd3);
        chk("irq_norm_pre", 32'(irq), 32'd0);
        cycle();
        chk("irq_norm_set", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;

        // irq_en=0 keeps irq low on a hit.
        wr(S_CTL, 32'd0, 1'b0);
        wr(S_SEC, 32'd2, 1'b0);
        wr(S_SUB, 32'd23999999, 1'b0);
        en = 1'b1;
        cycle();
        en = 1'b0;
        cycle();
        cycle();
        chk("irq_disabled", 32'(irq), 32'd0);

        // Asynchronous reset in the middle of normalisation.
        wr(S_SUB, 32'h3FFF_FFFF, 1'b0);
        repeat (5) cycle();
        chk("midnorm_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_sub", 32'(sub_cnt), 32'd0);
        chk("rst_sec", sec_cnt, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        rst = 1'b0;
        cycle();
        rd(S_CMP, 32'hFFFF_FFFF);

        // Worst-case normalisation from the maximum SUB value.
        wr(S_SUB, 32'h3FFF_FFFF, 1'b1);
        en     = 1'b1;
        cnt    = 0;
        pulses = 0;
        while (busy && cnt < 100) begin
            cnt++;
            cycle();
            if (sec_pulse) pulses++;
        end
        en = 1'b0;
        chk("maxnorm_cycles", cnt, 44);
        chk("maxnorm_sub", 32'(sub_cnt), 32'd17741823);
        chk("maxnorm_sec", sec_cnt, 32'd44);
        chk("maxnorm_no_pulse", pulses, 0);

        cycle();
        cycle();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
